// File: rtl/game_pkg.sv
// Shared screen geometry, coordinate widths and drawer state encoding.
package game_pkg;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 9;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StErase,
    StDraw,
    StDone
  } drawer_state_e;

endpackage

// File: rtl/rect_scanner.sv
// Row-major dx/dy scan of a RECT_W x RECT_H rectangle anchored at base_x/base_y.
module rect_scanner
  import game_pkg::*;
#(
  parameter int unsigned RECT_W = 4,
  parameter int unsigned RECT_H = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           step,
  input  logic [X_W-1:0] base_x,
  input  logic [Y_W-1:0] base_y,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           valid,
  output logic           last
);

  localparam int unsigned DxW = (RECT_W > 1) ? $clog2(RECT_W) : 1;
  localparam int unsigned DyW = (RECT_H > 1) ? $clog2(RECT_H) : 1;
  localparam logic [DxW-1:0] DxMax = DxW'(RECT_W - 1);
  localparam logic [DyW-1:0] DyMax = DyW'(RECT_H - 1);

  logic [DxW-1:0] dx_q;
  logic [DyW-1:0] dy_q;

  always_comb begin
    pix_x = base_x + X_W'(dx_q);
    pix_y = base_y + Y_W'(dy_q);
    valid = step && !start;
    last  = (dx_q == DxMax) && (dy_q == DyMax);
  end

  // Counters wrap to zero after the final pixel so back-to-back passes need no restart.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else if (start) begin
      dx_q <= '0;
      dy_q <= '0;
    end else if (step) begin
      if (dx_q == DxMax) begin
        dx_q <= '0;
        dy_q <= last ? '0 : dy_q + 1'b1;
      end else begin
        dx_q <= dx_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_drawer.sv
// Erases the previous paddle rectangle and draws the new one, one registered pixel per clock.
module paddle_drawer #(
  parameter int unsigned                     SCREEN_W  = game_pkg::SCREEN_W,
  parameter int unsigned                     SCREEN_H  = game_pkg::SCREEN_H,
  parameter int unsigned                     PADDLE_W  = 4,
  parameter int unsigned                     PADDLE_H  = 16,
  parameter logic [game_pkg::COLOUR_W-1:0]   FG_COLOUR = 3'b111,
  parameter logic [game_pkg::COLOUR_W-1:0]   BG_COLOUR = 3'b000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          moved,
  input  logic [game_pkg::X_W-1:0]      pos_x,
  input  logic [game_pkg::Y_W-1:0]      pos_y,
  output logic [game_pkg::X_W-1:0]      vga_x,
  output logic [game_pkg::Y_W-1:0]      vga_y,
  output logic [game_pkg::COLOUR_W-1:0] vga_colour,
  output logic                          vga_plot,
  output logic                          busy,
  output logic                          done
);

  import game_pkg::*;

  localparam logic [X_W-1:0] MaxX = X_W'(SCREEN_W - PADDLE_W);
  localparam logic [Y_W-1:0] MaxY = Y_W'(SCREEN_H - PADDLE_H);

  function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] v);
    return (v > MaxX) ? MaxX : v;
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] v);
    return (v > MaxY) ? MaxY : v;
  endfunction

  drawer_state_e state_q, state_d;

  logic [X_W-1:0] new_x_q, old_x_q, pend_x_q;
  logic [Y_W-1:0] new_y_q, old_y_q, pend_y_q;
  logic           old_valid_q, pending_q;

  logic [X_W-1:0]      vga_x_q;
  logic [Y_W-1:0]      vga_y_q;
  logic [COLOUR_W-1:0] vga_colour_q;
  logic                vga_plot_q, busy_q, done_q;

  logic           scan_start, scan_step, scan_valid, scan_last, latch_new;
  logic [X_W-1:0] scan_base_x, scan_pix_x;
  logic [Y_W-1:0] scan_base_y, scan_pix_y;

  always_comb begin
    state_d    = state_q;
    scan_start = 1'b0;
    scan_step  = 1'b0;
    latch_new  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (moved || pending_q) begin
          latch_new  = 1'b1;
          scan_start = 1'b1;
          state_d    = old_valid_q ? StErase : StDraw;
        end
      end
      StErase: begin
        scan_step = 1'b1;
        if (scan_last) state_d = StDraw;
      end
      StDraw: begin
        scan_step = 1'b1;
        if (scan_last) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign scan_base_x = (state_q == StErase) ? old_x_q : new_x_q;
  assign scan_base_y = (state_q == StErase) ? old_y_q : new_y_q;

  rect_scanner #(
    .RECT_W (PADDLE_W),
    .RECT_H (PADDLE_H)
  ) u_scanner (
    .clock  (clock),
    .reset  (reset),
    .start  (scan_start),
    .step   (scan_step),
    .base_x (scan_base_x),
    .base_y (scan_base_y),
    .pix_x  (scan_pix_x),
    .pix_y  (scan_pix_y),
    .valid  (scan_valid),
    .last   (scan_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      new_x_q     <= '0;
      new_y_q     <= '0;
      old_x_q     <= '0;
      old_y_q     <= '0;
      old_valid_q <= 1'b0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_new) begin
        // A fresh strobe in IDLE supersedes anything queued.
        new_x_q   <= moved ? clamp_x(pos_x) : pend_x_q;
        new_y_q   <= moved ? clamp_y(pos_y) : pend_y_q;
        pending_q <= 1'b0;
      end else if (moved && state_q != StIdle) begin
        pend_x_q  <= clamp_x(pos_x);
        pend_y_q  <= clamp_y(pos_y);
        pending_q <= 1'b1;
      end
      if (state_q == StDraw && scan_last) begin
        old_x_q     <= new_x_q;
        old_y_q     <= new_y_q;
        old_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= BG_COLOUR;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      vga_plot_q <= scan_valid;
      if (scan_valid) begin
        vga_x_q      <= scan_pix_x;
        vga_y_q      <= scan_pix_y;
        vga_colour_q <= (state_q == StErase) ? BG_COLOUR : FG_COLOUR;
      end
      busy_q <= (state_d != StIdle);
      done_q <= (state_q == StDone);
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_paddle_drawer.sv
// Self-checking bench: captures every plotted pixel and compares against a rectangle-list model.
module tb_paddle_drawer;

  localparam int PW = 4;
  localparam int PH = 16;
  localparam int MAXX = 320 - PW;
  localparam int MAXY = 120 - PH;
  localparam logic [2:0] FG = 3'b111;
  localparam logic [2:0] BG = 3'b000;

  typedef struct packed {
    logic [8:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    int px;
    int py;
    int ex;
    int ey;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       moved = 1'b0;
  logic [8:0] pos_x = '0;
  logic [6:0] pos_y = '0;
  logic [8:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  paddle_drawer dut (
    .clock      (clock),
    .reset      (reset),
    .moved      (moved),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   offscreen = 0;
  int   kedge = 0;
  pix_t cap_q[$];
  int   plot_cyc[$];
  int   done_cyc[$];
  pix_t exp_q[$];

  // Reference state: the rectangle currently on screen.
  int   m_valid = 0;
  int   m_x = 0;
  int   m_y = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (vga_plot) begin
      cap_q.push_back('{x: vga_x, y: vga_y, c: vga_colour});
      plot_cyc.push_back(cyc);
      if (vga_x > 9'd319 || vga_y > 7'd119) offscreen++;
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_rect(input int x, input int y, input logic [2:0] c);
    for (int dy = 0; dy < PH; dy++)
      for (int dx = 0; dx < PW; dx++)
        exp_q.push_back('{x: 9'(x + dx), y: 7'(y + dy), c: c});
  endtask

  task automatic model_update(input int px, input int py);
    int cx, cy;
    cx = (px > MAXX) ? MAXX : px;
    cy = (py > MAXY) ? MAXY : py;
    if (m_valid != 0) add_rect(m_x, m_y, BG);
    add_rect(cx, cy, FG);
    m_x = cx;
    m_y = cy;
    m_valid = 1;
  endtask

  task automatic clear_capture();
    cap_q.delete();
    plot_cyc.delete();
    done_cyc.delete();
    exp_q.delete();
  endtask

  task automatic pulse_moved(input int px, input int py);
    @(posedge clock);
    #1 moved = 1'b1;
    pos_x = 9'(px);
    pos_y = 7'(py);
    @(posedge clock);
    #1 kedge = cyc;
    moved = 1'b0;
  endtask

  task automatic wait_dones(input string name, input int n, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge clock);
      if (done) seen++;
    end
    check({name, "_timeout"}, seen, n);
    @(negedge clock);
  endtask

  task automatic compare_pixels(input string name);
    int mism, first;
    mism = 0;
    first = -1;
    check({name, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      if (cap_q[i] != exp_q[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    if (mism != 0)
      $display("  first bad pixel %0d: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", first,
               cap_q[first].x, cap_q[first].y, cap_q[first].c,
               exp_q[first].x, exp_q[first].y, exp_q[first].c);
    check({name, "_pixels"}, mism, 0);
  endtask

  task automatic run_update(input string name, input int px, input int py);
    clear_capture();
    model_update(px, py);
    pulse_moved(px, py);
    wait_dones(name, 1, 400);
    compare_pixels(name);
    if (plot_cyc.size() > 0) begin
      check({name, "_first_plot"}, plot_cyc[0], kedge + 1);
      check({name, "_contig"}, plot_cyc[$] - plot_cyc[0] + 1, exp_q.size());
      check({name, "_done_pulses"}, done_cyc.size(), 1);
      if (done_cyc.size() > 0) check({name, "_done_time"}, done_cyc[0], plot_cyc[$] + 1);
    end else begin
      check({name, "_no_plot"}, 0, 1);
    end
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_plot_after"}, int'(vga_plot), 0);
  endtask

  function automatic int first_fg_index();
    for (int i = 0; i < cap_q.size(); i++)
      if (cap_q[i].c == FG) return i;
    return -1;
  endfunction

  vec_t vecs[7];

  initial begin
    int idx;

    vecs[0] = '{px: 0,   py: 10,  ex: 0,   ey: 10};
    vecs[1] = '{px: 310, py: 50,  ex: 310, ey: 50};
    vecs[2] = '{px: 319, py: 119, ex: 316, ey: 104};
    vecs[3] = '{px: 316, py: 104, ex: 316, ey: 104};
    vecs[4] = '{px: 317, py: 0,   ex: 316, ey: 0};
    vecs[5] = '{px: 0,   py: 105, ex: 0,   ey: 104};
    vecs[6] = '{px: 511, py: 127, ex: 316, ey: 104};

    repeat (3) @(negedge clock);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(vga_x), 0);
    check("rst_y", int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), int'(BG));
    @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_update($sformatf("vec%0d", i), vecs[i].px, vecs[i].py);
      idx = first_fg_index();
      if (idx >= 0) begin
        check($sformatf("vec%0d_base_x", i), int'(cap_q[idx].x), vecs[i].ex);
        check($sformatf("vec%0d_base_y", i), int'(cap_q[idx].y), vecs[i].ey);
      end else begin
        check($sformatf("vec%0d_no_fg", i), 0, 1);
      end
    end

    for (int i = 0; i < 6; i++)
      run_update($sformatf("rand%0d", i), int'($urandom_range(0, 511)),
                 int'($urandom_range(0, 127)));

    // Two strobes during DRAW: only the latest is served once the current update completes.
    clear_capture();
    model_update(100, 30);
    model_update(0, 20);
    pulse_moved(100, 30);
    repeat (80) @(negedge clock);
    check("pend_busy", int'(busy), 1);
    pulse_moved(0, 0);
    repeat (2) @(posedge clock);
    pulse_moved(0, 20);
    wait_dones("pend", 2, 700);
    compare_pixels("pend");
    check("pend_dones", done_cyc.size(), 2);
    begin
      int zero_fg;
      zero_fg = 0;
      foreach (cap_q[i]) if (cap_q[i].x == 0 && cap_q[i].y == 0 && cap_q[i].c == FG) zero_fg++;
      check("pend_no_origin", zero_fg, 0);
    end

    // Asynchronous reset part-way through an erase pass.
    clear_capture();
    pulse_moved(50, 50);
    repeat (20) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("arst_plot", int'(vga_plot), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    m_valid = 0;
    run_update("after_rst", 5, 5);

    check("offscreen", offscreen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
